// File: rtl/mux_sched_pkg.sv
// Shared types and helpers for the round-robin output-mux scheduler.
package mux_sched_pkg;

  // Largest requester count the scheduler is sized for.
  localparam int MAX_REQ = 8;

  // IDLE: no grant held.
  // HOLD: a grant is held and the dwell counter is running.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Width of a requester index.
  function automatic int f_sel_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/mux_rr_scheduler_rr_pick.sv
// Combinational round-robin search. Returns the first set request bit,
// scanning upward from start_i and wrapping past N-1 back to 0.
module rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] start_i,
  output logic [W-1:0] pick_o,
  output logic         found_o
);

  int idx;

  // Scan N positions starting at start_i; keep the first hit only.
  always_comb begin
    pick_o  = '0;
    found_o = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(start_i) + i) % N;
      if (!found_o && req_i[idx[W-1:0]]) begin
        found_o = 1'b1;
        pick_o  = idx[W-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin time-sharing of a single 1-bit output among NUM_REQ
// requesters, with a fixed dwell of SLOT_CLKS cycles per grant.
// Optional manual override is compiled in with MUX_SCHED_MANUAL_EN.
module mux_rr_scheduler
  import mux_sched_pkg::*;
#(
  parameter  int NUM_REQ   = 2,
  parameter  int SLOT_CLKS = 25000000,
  localparam int SEL_W     = f_sel_w(NUM_REQ)
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic [NUM_REQ-1:0] i_Req,
  input  logic [NUM_REQ-1:0] i_Data,
`ifdef MUX_SCHED_MANUAL_EN
  input  logic               i_Manual,
  input  logic [SEL_W-1:0]   i_Manual_Sel,
`endif
  output logic [NUM_REQ-1:0] o_Grant,
  output logic [SEL_W-1:0]   o_Sel,
  output logic               o_Valid,
  output logic               o_Data,
  output logic               o_Slot_Done
);

  localparam int CNT_W = $clog2(SLOT_CLKS + 1);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q,   sel_d;
  logic [SEL_W-1:0]   last_q,  last_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               slot_done;

  logic [SEL_W-1:0]   start;
  logic [SEL_W-1:0]   pick;
  logic               found;
  logic               held;
  logic               expire;

`ifdef MUX_SCHED_MANUAL_EN
  logic               manual_q;
`endif

  // Search always begins one past the last grant. In HOLD last == sel,
  // so one picker serves both the IDLE pick and the expiry pick.
  assign start = (last_q == SEL_W'(NUM_REQ - 1)) ? '0 : last_q + 1'b1;

  rr_pick #(
    .N (NUM_REQ),
    .W (SEL_W)
  ) u_pick (
    .req_i   (i_Req),
    .start_i (start),
    .pick_o  (pick),
    .found_o (found)
  );

  assign held   = i_Req[sel_q];
  assign expire = (state_q == HOLD) && held && (cnt_q == CNT_W'(SLOT_CLKS - 1));

  // Next-state, grant and dwell-counter logic.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    slot_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = NUM_REQ'(1) << pick;
          sel_d   = pick;
          last_d  = pick;
          cnt_d   = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!held) begin
          // Holder let go: one dead cycle in IDLE, no slot-done.
          grant_d = '0;
          sel_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (expire) begin
          // Holder is still requesting, so the search always finds someone
          // (possibly the holder itself, keeping o_Grant continuous).
          slot_done = 1'b1;
          grant_d   = NUM_REQ'(1) << pick;
          sel_d     = pick;
          last_d    = pick;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef MUX_SCHED_MANUAL_EN
    if (i_Manual) begin
      // Manual select overrides arbitration; round-robin pointer untouched.
      state_d   = HOLD;
      sel_d     = i_Manual_Sel;
      grant_d   = (int'(i_Manual_Sel) < NUM_REQ) ? (NUM_REQ'(1) << i_Manual_Sel) : '0;
      last_d    = last_q;
      cnt_d     = '0;
      slot_done = 1'b0;
    end else if (manual_q) begin
      // Leaving manual mode restarts arbitration from IDLE.
      state_d   = IDLE;
      grant_d   = '0;
      sel_d     = '0;
      last_d    = last_q;
      cnt_d     = '0;
      slot_done = 1'b0;
    end
`endif
  end

  // State registers with synchronous reset; pointer parks at NUM_REQ-1
  // so the first search after reset starts at requester 0.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      last_q  <= SEL_W'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MUX_SCHED_MANUAL_EN
  // Remember manual mode so its falling edge can be detected.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) manual_q <= 1'b0;
    else         manual_q <= i_Manual;
  end
`endif

  assign o_Grant     = grant_q;
  assign o_Sel       = sel_q;
  assign o_Valid     = |grant_q;
  assign o_Data      = o_Valid ? i_Data[sel_q] : 1'b0;
  // A slot abandoned by reset never reports completion.
  assign o_Slot_Done = slot_done && !i_Reset;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Bench for mux_rr_scheduler: instance A (2 requesters, 4-cycle slot) runs
// the directed plan, instance B (3 requesters, 1-cycle slot) runs random
// requests throughout. Both are compared against a slot-level reference.
module tb_mux_rr_scheduler;

  logic       clk;
  logic       rst;
  logic [1:0] reqA, datA;
  logic [2:0] reqB, datB;

  logic [1:0] a_grant;
  logic [0:0] a_sel;
  logic       a_valid, a_data, a_done;
  logic [2:0] b_grant;
  logic [1:0] b_sel;
  logic       b_valid, b_data, b_done;

`ifdef MUX_SCHED_MANUAL_EN
  logic       manA, manB;
  logic [0:0] mselA;
  logic [1:0] mselB;
`endif

  int checks = 0;
  int errors = 0;

  // Reference: who holds the grant, last winner, cycles spent in this slot.
  int holder[2];
  int last_w[2];
  int el[2];

  mux_rr_scheduler #(.NUM_REQ(2), .SLOT_CLKS(4)) dut_a (
    .i_Clk(clk), .i_Reset(rst), .i_Req(reqA), .i_Data(datA),
`ifdef MUX_SCHED_MANUAL_EN
    .i_Manual(manA), .i_Manual_Sel(mselA),
`endif
    .o_Grant(a_grant), .o_Sel(a_sel), .o_Valid(a_valid),
    .o_Data(a_data), .o_Slot_Done(a_done)
  );

  mux_rr_scheduler #(.NUM_REQ(3), .SLOT_CLKS(1)) dut_b (
    .i_Clk(clk), .i_Reset(rst), .i_Req(reqB), .i_Data(datB),
`ifdef MUX_SCHED_MANUAL_EN
    .i_Manual(manB), .i_Manual_Sel(mselB),
`endif
    .o_Grant(b_grant), .o_Sel(b_sel), .o_Valid(b_valid),
    .o_Data(b_data), .o_Slot_Done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int n_of(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic int slot_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic logic [7:0] req_of(input int k);
    return (k == 0) ? {6'd0, reqA} : {5'd0, reqB};
  endfunction

  function automatic logic [7:0] dat_of(input int k);
    return (k == 0) ? {6'd0, datA} : {5'd0, datB};
  endfunction

  // First requester at or after 'from', wrapping; -1 when nobody asks.
  function automatic int search(input int k, input logic [7:0] r, input int from);
    for (int i = 0; i < n_of(k); i++) begin
      int p;
      p = (from + i) % n_of(k);
      if (r[p]) return p;
    end
    return -1;
  endfunction

  task automatic cmp(input string tag, input int k, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s inst%0d observed=%0h expected=%0h", tag, k, act, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic [7:0] r, d, g, s;
      logic       v, o, dn;
      int h;
      h  = holder[k];
      r  = req_of(k);
      d  = dat_of(k);
      g  = (k == 0) ? {6'd0, a_grant} : {5'd0, b_grant};
      s  = (k == 0) ? {7'd0, a_sel}   : {6'd0, b_sel};
      v  = (k == 0) ? a_valid : b_valid;
      o  = (k == 0) ? a_data  : b_data;
      dn = (k == 0) ? a_done  : b_done;
      cmp("grant", k, g, (h >= 0) ? (8'd1 << h) : 8'd0);
      cmp("valid", k, {7'd0, v}, {7'd0, h >= 0});
      if (h >= 0) cmp("sel", k, s, 8'(h));
      cmp("data", k, {7'd0, o}, {7'd0, (h >= 0) ? d[h] : 1'b0});
      cmp("slot_done", k, {7'd0, dn},
          {7'd0, !rst && h >= 0 && r[h] && el[k] == slot_of(k) - 1});
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      logic [7:0] r;
      int p;
      r = req_of(k);
      if (rst) begin
        holder[k] = -1; last_w[k] = n_of(k) - 1; el[k] = 0;
      end else if (holder[k] < 0) begin
        p = search(k, r, last_w[k] + 1);
        if (p >= 0) begin holder[k] = p; last_w[k] = p; el[k] = 0; end
      end else if (!r[holder[k]]) begin
        holder[k] = -1; el[k] = 0;
      end else if (el[k] == slot_of(k) - 1) begin
        p = search(k, r, holder[k] + 1);
        holder[k] = p; last_w[k] = p; el[k] = 0;
      end else begin
        el[k]++;
      end
    end
  endtask

  // Inputs change at negedge; outputs checked just after; model steps at posedge.
  task automatic tick(input bit chk);
    datA = 2'($urandom);
    datB = 3'($urandom);
    if ($urandom_range(0, 3) == 0) reqB = 3'($urandom);
    #1;
    if (chk) check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; reqA = 2'b11; datA = '0; reqB = 3'b111; datB = '0;
`ifdef MUX_SCHED_MANUAL_EN
    manA = 1'b0; mselA = '0; manB = 1'b0; mselB = '0;
`endif
    for (int k = 0; k < 2; k++) begin holder[k] = -1; last_w[k] = 0; el[k] = 0; end
    @(negedge clk);

    // Reset held two cycles with requests pending, then release.
    tick(1'b0);
    tick(1'b1);
    rst = 1'b0;

    // Both requesting: alternate every four cycles.
    repeat (20) tick(1'b1);

    // Only requester 1: continuous grant, slot-done every fourth cycle.
    reqA = 2'b10;
    repeat (12) tick(1'b1);

    // Requester 0 drops in the third cycle of its slot.
    rst = 1'b1; reqA = 2'b11;
    tick(1'b1);
    rst = 1'b0;
    repeat (3) tick(1'b1);
    reqA = 2'b10;
    repeat (4) tick(1'b1);

    // Reset while requester 1 holds; pointer must restart at 0.
    reqA = 2'b11;
    for (int i = 0; i < 10 && holder[0] != 1; i++) tick(1'b1);
    tick(1'b1);
    rst = 1'b1;
    tick(1'b1);
    rst = 1'b0;
    repeat (3) tick(1'b1);

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) reqA = 2'($urandom);
      rst = ($urandom_range(0, 63) == 0);
      tick(1'b1);
    end
    rst = 1'b0;

`ifdef MUX_SCHED_MANUAL_EN
    // Manual override of instance A to requester 1 while only 0 requests.
    rst = 1'b1;
    tick(1'b1);
    rst = 1'b0; manA = 1'b1; mselA = 1'b1; reqA = 2'b01;
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      datA = 2'($urandom);
      @(negedge clk);
      cmp("man_grant", 0, {6'd0, a_grant}, 8'h02);
      cmp("man_sel", 0, {7'd0, a_sel}, 8'h01);
      cmp("man_data", 0, {7'd0, a_data}, {7'd0, datA[1]});
      cmp("man_done", 0, {7'd0, a_done}, 8'h00);
      @(posedge clk);
    end
    manA = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmp("man_exit_idle", 0, {6'd0, a_grant}, 8'h00);
    @(posedge clk);
    @(negedge clk);
    cmp("man_exit_grant", 0, {6'd0, a_grant}, 8'h01);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_rr_scheduler.md
Name: mux_rr_scheduler

Overview:
- Time-shares one 1-bit output path (e.g. a shared LED) among NUM_REQ requesters.
- Round-robin policy with a fixed dwell slot per grant.
- Sits between debounced or toggled switch-state registers and the shared output mux.
- Generates the mux select that was previously driven by a fixed switch, plus a one-hot grant and slot-done strobe.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- SLOT_CLKS, 25000000, dwell cycles per grant (1 s at 25 MHz); minimum 1.
- SEL_W, derived localparam = $clog2(NUM_REQ), not overridable.

Ports:
- i_Clk  in  1  system clock; all logic on posedge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Req  in  NUM_REQ  level request per requester.
- i_Data  in  NUM_REQ  data bit per requester.
- o_Grant  out  NUM_REQ  registered one-hot grant, or all zero.
- o_Sel  out  SEL_W  registered index of the current grant.
- o_Valid  out  1  high while a grant is held; equals |o_Grant.
- o_Data  out  1  i_Data[o_Sel] when o_Valid, else 0; combinational from registered select.
- o_Slot_Done  out  1  one-cycle pulse when a slot expires with its request still held.

Behaviour:
- Reset (sampled on posedge i_Reset=1):
  - state=IDLE; o_Grant=0, o_Sel=0, o_Valid=0, o_Slot_Done=0, slot counter=0.
  - last-grant pointer = NUM_REQ-1, so the first search starts at index 0.
  - Reset mid-slot takes effect next edge; the slot is abandoned with no Slot_Done.
- States: IDLE, HOLD.
- IDLE:
  - If |i_Req: pick the first set bit searching last+1, last+2, … with wrap.
  - Register grant/sel, set last=pick, counter=0, go HOLD.
  - Latency is 1 cycle from request to grant.
- HOLD:
  - Counter increments each cycle; width $clog2(SLOT_CLKS+1).
  - If i_Req[o_Sel]==0: drop grant next cycle and go IDLE (one dead cycle); no Slot_Done.
  - Else, when counter==SLOT_CLKS-1:
    - Pulse o_Slot_Done in that same cycle.
    - Next cycle, regrant the round-robin pick starting from o_Sel+1 and reset the counter.
    - If the current holder is the only requester, it is re-granted; o_Grant never deasserts.
- Simultaneous request drop and slot expiry: the drop wins (IDLE, no Slot_Done).
- New requests arriving mid-slot do not preempt; they are considered only at expiry.
- SLOT_CLKS=1: grant rotates every cycle among active requesters; Slot_Done asserts every cycle.
- o_Grant is always one-hot or zero; o_Sel is stable while o_Valid=1 within a slot.

Optional Feature:
- Macro: MUX_SCHED_MANUAL_EN.
- Defined:
  - Adds ports i_Manual (in, 1) and i_Manual_Sel (in, SEL_W).
  - While i_Manual=1, the next cycle forces o_Grant/o_Sel to i_Manual_Sel with o_Valid=1, regardless of i_Req.
  - While in manual mode: counter held at 0, o_Slot_Done=0, last pointer unchanged.
  - On i_Manual falling, go IDLE.
  - i_Manual_Sel >= NUM_REQ grants nothing (o_Valid=0).
- Undefined: ports absent; pure round-robin behaviour as above.

Decomposition:
- Package mux_sched_pkg contains:
  - state typedef {IDLE, HOLD};
  - MAX_REQ=8;
  - function f_sel_w(n) returning $clog2(n).
- One combinational sub-module, rr_pick:
  - Inputs: req vector, start index.
  - Outputs: pick index, found flag.
  - Reused for both the IDLE pick and the expiry pick.

Test Plan (NUM_REQ=2, SLOT_CLKS=4 unless stated):
1. i_Reset=1 for 2 cycles with i_Req=11 -> all outputs 0 during reset; first cycle after release o_Grant=01, o_Sel=0.
2. i_Req=11 held -> o_Grant=01 for 4 cycles, then 10 for 4, repeating; o_Slot_Done pulses on every 4th granted cycle; o_Data tracks i_Data[o_Sel].
3. i_Req=10 only -> o_Grant=10 continuously; o_Slot_Done every 4 cycles; o_Valid never drops.
4. i_Req=11, req0 drops at slot cycle 2 -> o_Grant=00 next cycle, no Slot_Done; following cycle o_Grant=10.
5. i_Reset pulsed during HOLD on requester 1, i_Req=11 -> next cycle all outputs 0; after release o_Grant=01 (pointer reset).
6. With MUX_SCHED_MANUAL_EN: i_Manual=1, i_Manual_Sel=1, i_Req=01 -> o_Grant=10, o_Data=i_Data[1], o_Slot_Done stays 0; i_Manual=0 -> IDLE, then o_Grant=01.
